// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_ctrl_pkg : opcode/funct constants, md-op encoding, latency defaults     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mdu_ctrl_pkg;

  localparam int unsigned C_MUL_CYCLES = 5;
  localparam int unsigned C_DIV_CYCLES = 10;

  localparam logic [5:0] C_OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] C_OP_SPECIAL2 = 6'b011100;

  localparam logic [5:0] C_FN_MFHI  = 6'b010000;
  localparam logic [5:0] C_FN_MTHI  = 6'b010001;
  localparam logic [5:0] C_FN_MFLO  = 6'b010010;
  localparam logic [5:0] C_FN_MTLO  = 6'b010011;
  localparam logic [5:0] C_FN_MULT  = 6'b011000;
  localparam logic [5:0] C_FN_MULTU = 6'b011001;
  localparam logic [5:0] C_FN_DIV   = 6'b011010;
  localparam logic [5:0] C_FN_DIVU  = 6'b011011;

  // SPECIAL2 multiply-accumulate functs
  localparam logic [5:0] C_FN_MADD  = 6'b000000;
  localparam logic [5:0] C_FN_MADDU = 6'b000001;
  localparam logic [5:0] C_FN_MSUB  = 6'b000100;
  localparam logic [5:0] C_FN_MSUBU = 6'b000101;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_decode : Op/Funct -> multiply/divide instruction class (MDU_MADD_EN)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module md_decode
  import mdu_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic       o_is_md,
  output logic       o_start,
  output md_op_e     o_op,
  output logic       o_is_mfhi,
  output logic       o_is_mflo,
  output logic       o_is_mthi,
  output logic       o_is_mtlo
);

  always_comb begin
    o_start   = 1'b0;
    o_op      = MD_MULT;
    o_is_mfhi = 1'b0;
    o_is_mflo = 1'b0;
    o_is_mthi = 1'b0;
    o_is_mtlo = 1'b0;

    if (i_op == C_OP_SPECIAL) begin
      case (i_funct)
        C_FN_MULT:  begin o_start = 1'b1; o_op = MD_MULT;  end
        C_FN_MULTU: begin o_start = 1'b1; o_op = MD_MULTU; end
        C_FN_DIV:   begin o_start = 1'b1; o_op = MD_DIV;   end
        C_FN_DIVU:  begin o_start = 1'b1; o_op = MD_DIVU;  end
        C_FN_MFHI:  o_is_mfhi = 1'b1;
        C_FN_MFLO:  o_is_mflo = 1'b1;
        C_FN_MTHI:  o_is_mthi = 1'b1;
        C_FN_MTLO:  o_is_mtlo = 1'b1;
        default:    ;
      endcase
    end

`ifdef MDU_MADD_EN
    if (i_op == C_OP_SPECIAL2) begin
      case (i_funct)
        C_FN_MADD:  begin o_start = 1'b1; o_op = MD_MADD;  end
        C_FN_MADDU: begin o_start = 1'b1; o_op = MD_MADDU; end
        C_FN_MSUB:  begin o_start = 1'b1; o_op = MD_MSUB;  end
        C_FN_MSUBU: begin o_start = 1'b1; o_op = MD_MSUBU; end
        default:    ;
      endcase
    end
`endif

    o_is_md = o_start | o_is_mfhi | o_is_mflo | o_is_mthi | o_is_mtlo;
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_ctrl : E-stage multiply/divide control, HI/LO state, D-stage stall.    |
// | Optional MADD/MSUB family enabled by defining MDU_MADD_EN. Rev 1.0         |
// +----------------------------------------------------------------------------+
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = C_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = C_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       D_Op,
  input  logic [5:0]       D_Funct,
  input  logic [5:0]       E_Op,
  input  logic [5:0]       E_Funct,
  input  logic             Cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stall,
  output logic [WIDTH-1:0] MDOut,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned C_MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned C_CNT_W      = $clog2(C_MAX_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_MUL_LOAD = C_CNT_W'(MUL_CYCLES);
  localparam logic [C_CNT_W-1:0] C_DIV_LOAD = C_CNT_W'(DIV_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  // ---------------------------------------------------------------- decode
  logic   w_d_is_md, w_d_start, w_d_mfhi, w_d_mflo, w_d_mthi, w_d_mtlo;
  logic   w_e_is_md, w_e_start, w_e_mfhi, w_e_mflo, w_e_mthi, w_e_mtlo;
  md_op_e w_d_op, w_e_op;

  md_decode u_dec_d (
    .i_op      (D_Op),
    .i_funct   (D_Funct),
    .o_is_md   (w_d_is_md),
    .o_start   (w_d_start),
    .o_op      (w_d_op),
    .o_is_mfhi (w_d_mfhi),
    .o_is_mflo (w_d_mflo),
    .o_is_mthi (w_d_mthi),
    .o_is_mtlo (w_d_mtlo)
  );

  md_decode u_dec_e (
    .i_op      (E_Op),
    .i_funct   (E_Funct),
    .o_is_md   (w_e_is_md),
    .o_start   (w_e_start),
    .o_op      (w_e_op),
    .o_is_mfhi (w_e_mfhi),
    .o_is_mflo (w_e_mflo),
    .o_is_mthi (w_e_mthi),
    .o_is_mtlo (w_e_mtlo)
  );

  logic w_unused;
  assign w_unused = &{1'b0, w_d_start, w_d_op, w_d_mfhi, w_d_mflo, w_d_mthi, w_d_mtlo,
                      w_e_is_md, w_e_mflo};

  // ---------------------------------------------------------------- state
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic w_start;
  assign w_start = w_e_start & ~Cancel;

  // ---------------------------------------------------------------- datapath
  logic               w_sgn, w_a_neg, w_b_neg;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_divisor, w_q_mag, w_r_mag;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;
  logic [C_CNT_W-1:0] w_load;

  always_comb begin
    w_sgn   = md_is_signed(w_e_op);
    w_ext_a = w_sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    w_ext_b = w_sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    w_prod  = w_ext_a * w_ext_b;

    // Magnitude division gives truncation toward zero and also makes
    // most-negative / -1 fall out as most-negative with a zero remainder.
    w_a_neg   = w_sgn & A[WIDTH-1];
    w_b_neg   = w_sgn & B[WIDTH-1];
    w_mag_a   = w_a_neg ? -A : A;
    w_mag_b   = w_b_neg ? -B : B;
    w_divisor = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    w_q_mag   = w_mag_a / w_divisor;
    w_r_mag   = w_mag_a % w_divisor;

    {w_res_hi, w_res_lo} = w_prod;
    case (w_e_op)
      MD_DIV, MD_DIVU: begin
        if (B == '0) begin
          w_res_lo = '1;
          w_res_hi = A;
        end else begin
          w_res_lo = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
          w_res_hi = w_a_neg ? -w_r_mag : w_r_mag;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod;
      MD_MSUB, MD_MSUBU: {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod;
`endif
      default: ;
    endcase

    w_load = md_is_div(w_e_op) ? C_DIV_LOAD : C_MUL_LOAD;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (w_e_mthi && !Cancel) hi_d = A;
    if (w_e_mtlo && !Cancel) lo_d = A;

    // A forced restart discards the running result; otherwise the final
    // countdown step commits and takes priority over a same-cycle MT write.
    if (w_start) begin
      cnt_d     = w_load;
      pend_hi_d = w_res_hi;
      pend_lo_d = w_res_lo;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - C_CNT_ONE;
      if (cnt_q == C_CNT_ONE) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign Busy  = (cnt_q != '0);
  assign Stall = w_d_is_md & (w_start | Busy);
  assign MDOut = w_e_mfhi ? hi_q : lo_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
`default_nettype wire
